multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle sequencer for the MIPS-subset datapath: walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Decodes opcode/funct from the instruction register and drives per-state datapath enables and mux selects.
//  Memory accesses use a req/ready handshake with a bounded wait.
//  Illegal opcodes or a memory timeout halt the core until reset.
// PARAMETERS
//  WAIT_LIMIT  default 15  max cycles mem_req may stay high without mem_ready before a bus fault
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous, active-high reset
//  opcode     in   6  IR[31:26]; valid from DECODE onward
//  funct      in   6  IR[5:0]
//  zero       in   1  ALU zero flag (EXEC of beq)
//  mem_ready  in   1  memory completes the current access this cycle
//  mem_req    out  1  memory access request (FETCH, MEM)
//  mem_write  out  1  store qualifier for mem_req
//  ir_write   out  1  load IR from memory read data
//  pc_write   out  1  load PC from the npc mux
//  npc_sel    out  2  00 pc+4, 01 branch target, 10 jump target, 11 rs (jr)
//  alu_ctl    out  3  000 addu, 001 subu, 010 or, 011 lui, 100 slt
//  alu_src    out  1  0 = rt, 1 = extended immediate
//  ext_op     out  1  0 = zero-extend, 1 = sign-extend
//  reg_write  out  1  register file write enable
//  reg_dst    out  2  00 rt, 01 rd, 10 $31
//  mem_to_reg out  2  00 ALU result, 01 memory data, 10 pc+4 (jal link)
//  state      out  3  000 FETCH, 001 DECODE, 010 EXEC, 011 MEM, 100 WB, 101 HALT
//  fault      out  2  sticky: bit0 illegal instruction, bit1 bus timeout
// BEHAVIOUR
//  Reset: state=FETCH, fault=0, wait counter=0; all other outputs are combinational decodes of state.
//  Outputs not asserted in the current state are 0.
//  Rst mid-instruction abandons the instruction; PC and IR are untouched by this block.
//  Legal set: R-type (op 000000) addu 100001, subu 100011, slt 101010, jr 001000;
//   ori 001101, lui 001111, addi 001000, addiu 001001, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
//  addi never traps on overflow (behaves as addiu).
//  FETCH: mem_req=1. On mem_ready: ir_write=1, pc_write=1, npc_sel=00, go to DECODE.
//  DECODE:
//   - illegal op/funct: fault[0]<=1, go to HALT.
//   - j: pc_write=1, npc_sel=10, go to FETCH.
//   - jal: same as j, plus reg_write=1, reg_dst=10, mem_to_reg=10; go to FETCH.
//   - jr: pc_write=1, npc_sel=11, go to FETCH.
//   - otherwise go to EXEC.
//  EXEC (alu_ctl: addu/lw/sw/addi/addiu=000, subu/beq=001, ori=010, lui=011, slt=100):
//   - alu_src=1 for ori/lui/lw/sw/addi/addiu.
//   - ext_op=1 for lw/sw/addi/addiu/beq.
//   - beq: pc_write=zero, npc_sel=01, go to FETCH.
//   - lw/sw: go to MEM.
//   - all others: go to WB.
//  MEM: mem_req=1, mem_write=sw, alu_ctl/alu_src/ext_op held as in EXEC.
//   On mem_ready: lw goes to WB, sw goes to FETCH.
//  WB: reg_write=1; reg_dst=01 for R-type, else 00; mem_to_reg=01 for lw, else 00; go to FETCH.
//  Wait counter: clears on entry to FETCH/MEM and on mem_ready; increments each cycle mem_req=1 and mem_ready=0.
//   When it reaches WAIT_LIMIT with mem_ready still 0: fault[1]<=1, go to HALT.
//   mem_ready on the limit cycle wins (access completes, no fault).
//  HALT: all strobes 0; remains until rst.
//  Latency with zero-wait memory: j/jal/jr 2 cycles, beq 3, R/I ALU 4, sw 4, lw 5.
//  mem_ready outside FETCH/MEM is ignored.
// TESTING
//  addu, mem_ready tied 1 -> states 0,1,2,4,0; reg_write only in WB with reg_dst=01; pc_write only in FETCH.
//  lw with 3 wait cycles in MEM -> mem_req held 4 cycles; WB asserts mem_to_reg=01; total 8 cycles.
//  beq: zero=1 -> EXEC pc_write=1, npc_sel=01; zero=0 -> pc_write=0; both return to FETCH.
//  jal -> DECODE asserts pc_write, npc_sel=10, reg_write, reg_dst=10, mem_to_reg=10; next state FETCH.
//  opcode 111111 -> fault=01, state=HALT; held 20 cycles regardless of mem_ready; rst clears to FETCH.
//  mem_ready low for WAIT_LIMIT cycles in FETCH -> fault=10, HALT; rst asserted during MEM -> FETCH next cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Multi-cycle sequencer for a MIPS-subset datapath. Each instruction walks
//   FETCH -> DECODE -> EXEC -> MEM -> WB (stages skipped as the opcode allows).
//   Every datapath strobe and mux select is a combinational decode of the
//   current state plus opcode/funct. Memory accesses use a req/ready handshake
//   guarded by a wait counter. An illegal instruction or a memory timeout
//   parks the sequencer in HALT with a sticky fault code until reset.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   000   | FETCH  : request instruction word, load IR and PC+4
//   001   | DECODE : decode opcode/funct, resolve j/jal/jr, trap illegal
//   010   | EXEC   : ALU operation, beq resolution
//   011   | MEM    : data load/store handshake
//   100   | WB     : register file write-back
//   101   | HALT   : faulted, all strobes off until rst
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   opcode, funct      IR fields (valid from DECODE onward)
//   zero               ALU zero flag for beq
//   mem_ready          memory access completes this cycle
//   mem_req/mem_write  memory request and store qualifier
//   ir_write, pc_write IR and PC load enables
//   npc_sel            00 pc+4, 01 branch, 10 jump, 11 rs
//   alu_ctl            000 addu, 001 subu, 010 or, 011 lui, 100 slt
//   alu_src, ext_op    ALU B operand select, immediate sign-extend
//   reg_write, reg_dst register write enable, 00 rt / 01 rd / 10 $31
//   mem_to_reg         00 ALU, 01 memory data, 10 pc+4
//   state, fault       current state, sticky {timeout, illegal}
module multicycle_controller #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] npc_sel,
  output logic [2:0] alu_ctl,
  output logic       alu_src,
  output logic       ext_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [2:0] state,
  output logic [1:0] fault
);

  localparam logic [2:0] S_FETCH  = 3'b000;
  localparam logic [2:0] S_DECODE = 3'b001;
  localparam logic [2:0] S_EXEC   = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB     = 3'b100;
  localparam logic [2:0] S_HALT   = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Counter holds the number of stalled cycles so far; the stall that would
  // make it reach WAIT_LIMIT is the fault cycle, so it never stores WAIT_LIMIT.
  localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        fault_q, fault_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic is_rtype, is_addu, is_subu, is_slt, is_jr;
  logic is_ori, is_lui, is_addi, is_addiu, is_lw, is_sw, is_beq, is_j, is_jal;
  logic legal;
  logic [2:0] alu_ctl_dec;
  logic       alu_src_dec, ext_op_dec;
  logic       timeout;

  always_comb begin
    is_rtype = (opcode == OP_RTYPE);
    is_addu  = is_rtype && (funct == FN_ADDU);
    is_subu  = is_rtype && (funct == FN_SUBU);
    is_slt   = is_rtype && (funct == FN_SLT);
    is_jr    = is_rtype && (funct == FN_JR);
    is_ori   = (opcode == OP_ORI);
    is_lui   = (opcode == OP_LUI);
    is_addi  = (opcode == OP_ADDI);
    is_addiu = (opcode == OP_ADDIU);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    is_j     = (opcode == OP_J);
    is_jal   = (opcode == OP_JAL);
    legal    = is_addu || is_subu || is_slt || is_jr || is_ori || is_lui ||
               is_addi || is_addiu || is_lw || is_sw || is_beq || is_j || is_jal;

    alu_ctl_dec = 3'b000;
    if (is_subu || is_beq) alu_ctl_dec = 3'b001;
    else if (is_ori)       alu_ctl_dec = 3'b010;
    else if (is_lui)       alu_ctl_dec = 3'b011;
    else if (is_slt)       alu_ctl_dec = 3'b100;

    alu_src_dec = is_ori || is_lui || is_lw || is_sw || is_addi || is_addiu;
    ext_op_dec  = is_lw || is_sw || is_addi || is_addiu || is_beq;
  end

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    wait_d     = '0;
    timeout    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    npc_sel    = 2'b00;
    alu_ctl    = 3'b000;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;

    // Stall tracking shared by FETCH and MEM; ready on the last allowed
    // cycle still completes the access.
    if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
      if (wait_q == WAIT_LAST) timeout = 1'b1;
      else                     wait_d  = wait_q + 1'b1;
    end

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          fault_d[0] = 1'b1;
          state_d    = S_HALT;
        end else if (is_j || is_jal) begin
          pc_write = 1'b1;
          npc_sel  = 2'b10;
          if (is_jal) begin
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
          end
          state_d = S_FETCH;
        end else if (is_jr) begin
          pc_write = 1'b1;
          npc_sel  = 2'b11;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_ctl = alu_ctl_dec;
        alu_src = alu_src_dec;
        ext_op  = ext_op_dec;
        if (is_beq) begin
          pc_write = zero;
          npc_sel  = 2'b01;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_write = is_sw;
        alu_ctl   = alu_ctl_dec;
        alu_src   = alu_src_dec;
        ext_op    = ext_op_dec;
        if (mem_ready) state_d = is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype ? 2'b01 : 2'b00;
        mem_to_reg = is_lw ? 2'b01 : 2'b00;
        state_d    = S_FETCH;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    if (timeout) begin
      fault_d[1] = 1'b1;
      state_d    = S_HALT;
      wait_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      fault_q <= 2'b00;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
    end
  end

  assign state = state_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, ir_write, pc_write;
  logic [1:0] npc_sel;
  logic [2:0] alu_ctl;
  logic       alu_src, ext_op, reg_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic [2:0] state;
  logic [1:0] fault;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .npc_sel(npc_sel),
    .alu_ctl(alu_ctl), .alu_src(alu_src), .ext_op(ext_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .state(state), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  // walk FETCH (ready) into DECODE
  task automatic fetch_ok();
    mem_ready = 1'b1;
    settle();
    chk("fetch_state", state, 3'd0);
    chk("fetch_ir_write", ir_write, 1'b1);
    step();
  endtask

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    settle();

    // reset state
    chk("rst_state", state, 3'd0);
    chk("rst_fault", fault, 2'b00);
    chk("rst_mem_req", mem_req, 1'b1);
    chk("rst_pc_write_noready", pc_write, 1'b0);

    // addu with zero-wait memory: 0,1,2,4,0
    set_instr(6'b000000, 6'b100001);
    mem_ready = 1'b1;
    settle();
    chk("addu_f_pc_write", pc_write, 1'b1);
    chk("addu_f_npc_sel", npc_sel, 2'b00);
    chk("addu_f_reg_write", reg_write, 1'b0);
    step();
    chk("addu_d_state", state, 3'd1);
    chk("addu_d_pc_write", pc_write, 1'b0);
    chk("addu_d_reg_write", reg_write, 1'b0);
    step();
    chk("addu_e_state", state, 3'd2);
    chk("addu_e_alu_ctl", alu_ctl, 3'b000);
    chk("addu_e_alu_src", alu_src, 1'b0);
    chk("addu_e_pc_write", pc_write, 1'b0);
    step();
    chk("addu_w_state", state, 3'd4);
    chk("addu_w_reg_write", reg_write, 1'b1);
    chk("addu_w_reg_dst", reg_dst, 2'b01);
    chk("addu_w_mem_to_reg", mem_to_reg, 2'b00);
    chk("addu_w_pc_write", pc_write, 1'b0);
    step();
    chk("addu_done_state", state, 3'd0);

    // lw with 3 wait cycles in MEM: 8 cycles total
    set_instr(6'b100011, 6'b000000);
    fetch_ok();
    chk("lw_d_state", state, 3'd1);
    step();
    chk("lw_e_alu_src", alu_src, 1'b1);
    chk("lw_e_ext_op", ext_op, 1'b1);
    chk("lw_e_alu_ctl", alu_ctl, 3'b000);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("lw_m_wait_state", state, 3'd3);
      chk("lw_m_wait_req", mem_req, 1'b1);
      chk("lw_m_wait_write", mem_write, 1'b0);
      step();
    end
    mem_ready = 1'b1;
    settle();
    chk("lw_m_last_state", state, 3'd3);
    chk("lw_m_last_req", mem_req, 1'b1);
    chk("lw_m_ext_held", ext_op, 1'b1);
    step();
    chk("lw_w_state", state, 3'd4);
    chk("lw_w_mem_to_reg", mem_to_reg, 2'b01);
    chk("lw_w_reg_dst", reg_dst, 2'b00);
    chk("lw_w_mem_req", mem_req, 1'b0);
    step();
    chk("lw_done_state", state, 3'd0);
    chk("lw_fault", fault, 2'b00);

    // sw: MEM asserts mem_write, returns to FETCH
    set_instr(6'b101011, 6'b000000);
    fetch_ok();
    step();
    step();
    chk("sw_m_state", state, 3'd3);
    chk("sw_m_mem_write", mem_write, 1'b1);
    chk("sw_m_alu_src", alu_src, 1'b1);
    step();
    chk("sw_done_state", state, 3'd0);

    // beq taken and not taken
    set_instr(6'b000100, 6'b000000);
    zero = 1'b1;
    fetch_ok();
    step();
    chk("beq1_state", state, 3'd2);
    chk("beq1_pc_write", pc_write, 1'b1);
    chk("beq1_npc_sel", npc_sel, 2'b01);
    chk("beq1_alu_ctl", alu_ctl, 3'b001);
    chk("beq1_ext_op", ext_op, 1'b1);
    step();
    chk("beq1_done", state, 3'd0);
    zero = 1'b0;
    fetch_ok();
    step();
    chk("beq0_pc_write", pc_write, 1'b0);
    step();
    chk("beq0_done", state, 3'd0);

    // jal resolves in DECODE
    set_instr(6'b000011, 6'b000000);
    fetch_ok();
    chk("jal_state", state, 3'd1);
    chk("jal_pc_write", pc_write, 1'b1);
    chk("jal_npc_sel", npc_sel, 2'b10);
    chk("jal_reg_write", reg_write, 1'b1);
    chk("jal_reg_dst", reg_dst, 2'b10);
    chk("jal_mem_to_reg", mem_to_reg, 2'b10);
    step();
    chk("jal_done", state, 3'd0);

    // j and jr
    set_instr(6'b000010, 6'b000000);
    fetch_ok();
    chk("j_npc_sel", npc_sel, 2'b10);
    chk("j_reg_write", reg_write, 1'b0);
    step();
    chk("j_done", state, 3'd0);
    set_instr(6'b000000, 6'b001000);
    fetch_ok();
    chk("jr_npc_sel", npc_sel, 2'b11);
    chk("jr_pc_write", pc_write, 1'b1);
    step();
    chk("jr_done", state, 3'd0);

    // immediate ALU ops
    set_instr(6'b001101, 6'b000000);
    fetch_ok();
    step();
    chk("ori_alu_ctl", alu_ctl, 3'b010);
    chk("ori_ext_op", ext_op, 1'b0);
    chk("ori_alu_src", alu_src, 1'b1);
    step();
    chk("ori_w_reg_dst", reg_dst, 2'b00);
    step();
    set_instr(6'b001111, 6'b000000);
    fetch_ok();
    step();
    chk("lui_alu_ctl", alu_ctl, 3'b011);
    step(); step();
    set_instr(6'b001000, 6'b000000);
    fetch_ok();
    step();
    chk("addi_alu_ctl", alu_ctl, 3'b000);
    chk("addi_ext_op", ext_op, 1'b1);
    step(); step();
    set_instr(6'b000000, 6'b101010);
    fetch_ok();
    step();
    chk("slt_alu_ctl", alu_ctl, 3'b100);
    step();
    chk("slt_w_reg_dst", reg_dst, 2'b01);
    step();
    set_instr(6'b000000, 6'b100011);
    fetch_ok();
    step();
    chk("subu_alu_ctl", alu_ctl, 3'b001);
    step(); step();
    chk("subu_done", state, 3'd0);

    // illegal opcode: HALT held regardless of mem_ready, cleared by rst
    set_instr(6'b111111, 6'b000000);
    fetch_ok();
    chk("ill_d_pc_write", pc_write, 1'b0);
    step();
    chk("ill_state", state, 3'd5);
    chk("ill_fault", fault, 2'b01);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      step();
      chk("ill_hold_state", state, 3'd5);
      chk("ill_hold_req", mem_req, 1'b0);
    end
    chk("ill_hold_fault", fault, 2'b01);
    do_reset();
    chk("ill_rst_state", state, 3'd0);
    chk("ill_rst_fault", fault, 2'b00);

    // illegal R-type funct
    set_instr(6'b000000, 6'b000000);
    fetch_ok();
    step();
    chk("illfn_state", state, 3'd5);
    chk("illfn_fault", fault, 2'b01);
    do_reset();

    // ready on the 15th stalled FETCH cycle still completes
    set_instr(6'b000010, 6'b000000);
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("lim_ok_still_fetch", state, 3'd0);
    mem_ready = 1'b1;
    step();
    chk("lim_ok_state", state, 3'd1);
    chk("lim_ok_fault", fault, 2'b00);
    step();
    chk("lim_ok_back", state, 3'd0);

    // 15 stalled FETCH cycles -> bus fault
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("to_pre_state", state, 3'd0);
    chk("to_pre_fault", fault, 2'b00);
    step();
    chk("to_state", state, 3'd5);
    chk("to_fault", fault, 2'b10);
    mem_ready = 1'b1;
    step();
    chk("to_hold", state, 3'd5);
    do_reset();
    chk("to_rst_state", state, 3'd0);

    // rst asserted during MEM returns to FETCH next cycle
    set_instr(6'b100011, 6'b000000);
    fetch_ok();
    step();
    mem_ready = 1'b0;
    step();
    chk("rmem_in_mem", state, 3'd3);
    rst = 1'b1;
    step();
    chk("rmem_state", state, 3'd0);
    chk("rmem_fault", fault, 2'b00);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
